// File: rtl/mode_switch_ctrl_if.sv
// Bundle between the mode switches / player sources and the mode controller.
// The master side drives the mode request and source buses; the slave side is the controller.
interface mode_switch_ctrl_if #(
    parameter int N_MODES = 3,
    parameter int NOTE_W  = 4,
    parameter int LED_W   = 7,
    parameter int OCT_W   = 2,
    parameter int NUM_W   = 4
);
    logic [N_MODES-1:0]        mode;
    logic [N_MODES*NOTE_W-1:0] src_note;
    logic [N_MODES*LED_W-1:0]  src_led;
    logic [N_MODES*OCT_W-1:0]  src_octave;
    logic [N_MODES*NUM_W-1:0]  src_num;

    logic [NOTE_W-1:0]         note_out;
    logic [LED_W-1:0]          led_out;
    logic [OCT_W-1:0]          octave_out;
    logic [NUM_W-1:0]          num;
    logic [N_MODES-1:0]        src_restart;
    logic [N_MODES-1:0]        active_mode;
    logic                      switching;
    logic                      mode_err;

    modport master (
        output mode, src_note, src_led, src_octave, src_num,
        input  note_out, led_out, octave_out, num, src_restart, active_mode, switching, mode_err
    );

    modport slave (
        input  mode, src_note, src_led, src_octave, src_num,
        output note_out, led_out, octave_out, num, src_restart, active_mode, switching, mode_err
    );
endinterface

// File: rtl/mode_switch_ctrl.sv
// Top-level mode controller: debounces a one-hot mode request, mutes the outputs across
// a mode change and pulses the restart line of the newly selected player source.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  ACTIVE  | outputs track the source selected by active_mode
//  MUTE    | note/led forced to 0 for MUTE_CYCLES while the new mode settles
//  RESTART | one cycle: active_mode takes the pending mode, restart pulse out
module mode_switch_ctrl #(
    parameter int N_MODES       = 3,
    parameter int NOTE_W        = 4,
    parameter int LED_W         = 7,
    parameter int OCT_W         = 2,
    parameter int NUM_W         = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int MUTE_CYCLES   = 16,
    parameter int DEFAULT_MODE  = 0,
    parameter int DEFAULT_OCT   = 1
) (
    input logic               clk,
    input logic               reset,
    mode_switch_ctrl_if.slave bus
);

    localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int MC_W = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam logic [SC_W-1:0]    STABLE_MAX  = SC_W'(STABLE_CYCLES - 1);
    localparam logic [MC_W-1:0]    MUTE_MAX    = MC_W'(MUTE_CYCLES - 1);
    localparam logic [N_MODES-1:0] DEF_ONEHOT  = N_MODES'(1) << DEFAULT_MODE;
    localparam logic [OCT_W-1:0]   DEF_OCT_VAL = OCT_W'(DEFAULT_OCT);

    typedef enum logic [1:0] {
        ACTIVE  = 2'd0,
        MUTE    = 2'd1,
        RESTART = 2'd2
    } state_t;

    state_t             state;
    logic [N_MODES-1:0] mode_q;
    logic               mode_err_q;
    logic [SC_W-1:0]    stable_cnt;
    logic [N_MODES-1:0] active_mode_q;
    logic [N_MODES-1:0] pending_mode;
    logic [MC_W-1:0]    mute_cnt;
    logic [NOTE_W-1:0]  note_q;
    logic [LED_W-1:0]   led_q;
    logic [OCT_W-1:0]   oct_q;
    logic [NUM_W-1:0]   num_q;
    logic [N_MODES-1:0] restart_q;
    logic               switching_q;

    logic               sample_ok;
    logic               accept_valid;
    logic [NOTE_W-1:0]  sel_note;
    logic [LED_W-1:0]   sel_led;
    logic [OCT_W-1:0]   sel_oct;
    logic [NUM_W-1:0]   sel_num;

    assign sample_ok = $onehot(bus.mode);

    // The stability count reaches STABLE_MAX after STABLE_CYCLES identical valid samples.
    assign accept_valid = !mode_err_q && (stable_cnt == STABLE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= DEF_ONEHOT;
            mode_err_q <= 1'b0;
            stable_cnt <= '0;
        end else begin
            mode_q     <= bus.mode;
            mode_err_q <= !sample_ok;
            if (!sample_ok || (bus.mode != mode_q)) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_MAX) begin
                stable_cnt <= stable_cnt + SC_W'(1);
            end
        end
    end

    always_comb begin
        sel_note = '0;
        sel_led  = '0;
        sel_oct  = '0;
        sel_num  = '0;
        for (int i = 0; i < N_MODES; i++) begin
            if (active_mode_q[i]) begin
                sel_note = bus.src_note[i*NOTE_W +: NOTE_W];
                sel_led  = bus.src_led[i*LED_W +: LED_W];
                sel_oct  = bus.src_octave[i*OCT_W +: OCT_W];
                sel_num  = bus.src_num[i*NUM_W +: NUM_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ACTIVE;
            active_mode_q <= DEF_ONEHOT;
            pending_mode  <= DEF_ONEHOT;
            mute_cnt      <= '0;
            note_q        <= '0;
            led_q         <= '0;
            oct_q         <= DEF_OCT_VAL;
            num_q         <= '0;
            restart_q     <= '0;
            switching_q   <= 1'b0;
        end else begin
            restart_q <= '0;
            case (state)
                ACTIVE: begin
                    if (accept_valid && (mode_q != active_mode_q)) begin
                        state        <= MUTE;
                        pending_mode <= mode_q;
                        mute_cnt     <= '0;
                        switching_q  <= 1'b1;
                        note_q       <= '0;
                        led_q        <= '0;
                    end else begin
                        switching_q <= 1'b0;
                        note_q      <= sel_note;
                        led_q       <= sel_led;
                        oct_q       <= sel_oct;
                        num_q       <= sel_num;
                    end
                end
                MUTE: begin
                    note_q <= '0;
                    led_q  <= '0;
                    // A newer accepted request retargets the switch and restarts the gap.
                    if (accept_valid && (mode_q != pending_mode)) begin
                        pending_mode <= mode_q;
                        mute_cnt     <= '0;
                    end else if (mute_cnt == MUTE_MAX) begin
                        if (pending_mode == active_mode_q) begin
                            state       <= ACTIVE;
                            switching_q <= 1'b0;
                        end else begin
                            state         <= RESTART;
                            active_mode_q <= pending_mode;
                            restart_q     <= pending_mode;
                        end
                    end else begin
                        mute_cnt <= mute_cnt + MC_W'(1);
                    end
                end
                RESTART: begin
                    state       <= ACTIVE;
                    switching_q <= 1'b0;
                    note_q      <= '0;
                    led_q       <= '0;
                end
                default: begin
                    state       <= ACTIVE;
                    switching_q <= 1'b0;
                    note_q      <= '0;
                    led_q       <= '0;
                end
            endcase
        end
    end

    assign bus.note_out    = note_q;
    assign bus.led_out     = led_q;
    assign bus.octave_out  = oct_q;
    assign bus.num         = num_q;
    assign bus.src_restart = restart_q;
    assign bus.active_mode = active_mode_q;
    assign bus.switching   = switching_q;
    assign bus.mode_err    = mode_err_q;

endmodule
